back_icon_eu_rx_port: RTL and testbench

//  Receive end of the backend interconnect (icon) for one execution unit (EU).

---
 rtl/back_icon_eu_rx_port_pkg.sv | 45 ++++
 rtl/back_icon_eu_rx_port_slot.sv | 87 ++++++++
 rtl/back_icon_eu_rx_port.sv | 118 +++++++++++
 tb/tb_back_icon_eu_rx_port.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/back_icon_eu_rx_port_pkg.sv
// Shared datatypes for the backend interconnect (icon) receive port of an execution unit.
// Producer addresses, receiver lists and operand-wait slot records.
package back_icon_eu_rx_port_pkg;

  localparam int ICON_NUM_EUS = 8;
  localparam int ICON_EU_W    = 3;
  localparam int ICON_UNIT_W  = 3;
  localparam int ICON_DATA_W  = 32;

  typedef struct packed {
    logic [ICON_EU_W-1:0]   eu;
    logic [ICON_UNIT_W-1:0] unit;
  } type_exec_unit_addr;

  typedef struct packed {
    logic [ICON_NUM_EUS-1:0] eus;
  } type_icon_receivers_list;

  typedef struct packed {
    logic                   present;
    type_exec_unit_addr     tag;
    logic [ICON_DATA_W-1:0] data;
  } type_icon_rx_operand;

  typedef struct packed {
    logic                      valid;
    type_icon_rx_operand [1:0] ops;
  } type_icon_rx_slot;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_WAIT,
    SLOT_READY
  } type_icon_rx_slot_state;

  function automatic type_icon_rx_slot_state slot_state(input logic valid,
                                                        input logic [1:0] present);
    type_icon_rx_slot_state st;
    if (!valid)        st = SLOT_IDLE;
    else if (&present) st = SLOT_READY;
    else               st = SLOT_WAIT;
    return st;
  endfunction

endpackage

// File: rtl/back_icon_eu_rx_port_slot.sv
// One operand-wait slot: holds two tagged operands and captures them from matching icon channels.
// The alloc path is matched too, so a delivery coinciding with allocation is not lost.
module back_icon_rx_slot
  import back_icon_eu_rx_port_pkg::*;
#(
  parameter int NUM_ICON_CHANNELS = 4,
  parameter int DATA_WIDTH        = 32
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         alloc_i,
  input  logic                                         free_i,
  input  type_exec_unit_addr [1:0]                     alloc_tag_i,
  input  logic [1:0]                                   alloc_rdy_i,
  input  logic [1:0][DATA_WIDTH-1:0]                   alloc_data_i,
  input  logic [NUM_ICON_CHANNELS-1:0]                 ch_en_i,
  input  type_exec_unit_addr [NUM_ICON_CHANNELS-1:0]   ch_src_i,
  input  logic [NUM_ICON_CHANNELS-1:0][DATA_WIDTH-1:0] ch_data_i,
  output logic                                         valid_o,
  output logic                                         ready_o,
  output logic [NUM_ICON_CHANNELS-1:0]                 match_o,
  output logic [1:0][DATA_WIDTH-1:0]                   data_o
);

  logic                        valid_q, valid_d;
  logic [1:0]                  present_q, present_d;
  type_exec_unit_addr [1:0]    tag_q, tag_d;
  logic [1:0][DATA_WIDTH-1:0]  data_q, data_d;
  logic [1:0]                  waiting;
  type_exec_unit_addr [1:0]    cmp_tag;

  always_comb begin
    valid_d   = valid_q;
    present_d = present_q;
    tag_d     = tag_q;
    data_d    = data_q;
    match_o   = '0;
    waiting   = '0;
    cmp_tag   = tag_q;

    if (alloc_i) begin
      valid_d   = 1'b1;
      present_d = alloc_rdy_i;
      tag_d     = alloc_tag_i;
      data_d    = alloc_data_i;
      waiting   = ~alloc_rdy_i;
      cmp_tag   = alloc_tag_i;
    end else begin
      waiting = {2{valid_q}} & ~present_q;
      if (free_i) begin
        valid_d   = 1'b0;
        present_d = '0;
      end
    end

    // Descending scan so the lowest matching channel is the last writer of the operand data.
    for (int k = 0; k < 2; k++) begin
      for (int ch = NUM_ICON_CHANNELS - 1; ch >= 0; ch--) begin
        if (ch_en_i[ch] && waiting[k] && (ch_src_i[ch] == cmp_tag[k])) begin
          match_o[ch]  = 1'b1;
          present_d[k] = 1'b1;
          data_d[k]    = ch_data_i[ch];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      present_q <= '0;
    end else begin
      valid_q   <= valid_d;
      present_q <= present_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign valid_o = valid_q;
  assign ready_o = (slot_state(valid_q, present_q) == SLOT_READY);
  assign data_o  = data_q;

endmodule

// File: rtl/back_icon_eu_rx_port.sv
// Icon receive port for one execution unit: operand-wait slots, per-channel delivery success,
// and a valid/ready issue port that freezes its selection while stalled.
module back_icon_eu_rx_port
  import back_icon_eu_rx_port_pkg::*;
#(
  parameter int NUM_ICON_CHANNELS = 4,
  parameter int NUM_SLOTS         = 4,
  parameter int DATA_WIDTH        = 32,
  parameter int EU_IDX            = 0
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         alloc_valid_i,
  output logic                                         alloc_ready_o,
  input  type_exec_unit_addr [1:0]                     alloc_tag_i,
  input  logic [1:0]                                   alloc_rdy_i,
  input  logic [1:0][DATA_WIDTH-1:0]                   alloc_data_i,
  input  logic [NUM_ICON_CHANNELS-1:0]                 ch_en_i,
  input  type_exec_unit_addr [NUM_ICON_CHANNELS-1:0]   ch_src_i,
  input  logic [NUM_ICON_CHANNELS-1:0][DATA_WIDTH-1:0] ch_data_i,
  output logic [NUM_ICON_CHANNELS-1:0]                 success_o,
  output logic                                         issue_valid_o,
  input  logic                                         issue_ready_i,
  output logic [1:0][DATA_WIDTH-1:0]                   issue_data_o,
  output logic [$clog2(NUM_SLOTS)-1:0]                 issue_slot_o
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  if (EU_IDX < 0 || EU_IDX >= ICON_NUM_EUS || NUM_SLOTS < 2) begin : g_param_check
    $error("back_icon_eu_rx_port: EU_IDX or NUM_SLOTS out of range");
  end

  logic [NUM_SLOTS-1:0]               slot_valid, slot_ready, slot_alloc, slot_free;
  logic [NUM_ICON_CHANNELS-1:0]       slot_match [NUM_SLOTS];
  logic [1:0][DATA_WIDTH-1:0]         slot_data  [NUM_SLOTS];

  logic              free_found, rdy_found;
  logic [SLOT_W-1:0] free_idx, rdy_idx, sel_slot;
  logic              alloc_fire, issue_fire;
  logic              hold_q, hold_d;
  logic [SLOT_W-1:0] hold_slot_q, hold_slot_d;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    rdy_found  = 1'b0;
    rdy_idx    = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (!slot_valid[s]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(s);
      end
      if (slot_ready[s]) begin
        rdy_found = 1'b1;
        rdy_idx   = SLOT_W'(s);
      end
    end
  end

  assign alloc_ready_o = free_found;
  assign alloc_fire    = alloc_valid_i & alloc_ready_o & reset_n;

  // A stalled issue keeps its slot even if a lower-index slot becomes ready meanwhile.
  assign sel_slot      = hold_q ? hold_slot_q : rdy_idx;
  assign issue_valid_o = hold_q | rdy_found;
  assign issue_fire    = issue_valid_o & issue_ready_i;
  assign issue_slot_o  = issue_valid_o ? sel_slot : '0;
  assign issue_data_o  = issue_valid_o ? slot_data[sel_slot] : '0;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    assign slot_alloc[s] = alloc_fire && (free_idx == SLOT_W'(s));
    assign slot_free[s]  = issue_fire && (sel_slot == SLOT_W'(s));

    back_icon_rx_slot #(
      .NUM_ICON_CHANNELS (NUM_ICON_CHANNELS),
      .DATA_WIDTH        (DATA_WIDTH)
    ) u_slot (
      .clk          (clk),
      .reset_n      (reset_n),
      .alloc_i      (slot_alloc[s]),
      .free_i       (slot_free[s]),
      .alloc_tag_i  (alloc_tag_i),
      .alloc_rdy_i  (alloc_rdy_i),
      .alloc_data_i (alloc_data_i),
      .ch_en_i      (ch_en_i),
      .ch_src_i     (ch_src_i),
      .ch_data_i    (ch_data_i),
      .valid_o      (slot_valid[s]),
      .ready_o      (slot_ready[s]),
      .match_o      (slot_match[s]),
      .data_o       (slot_data[s])
    );
  end

  always_comb begin
    success_o = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      success_o = success_o | slot_match[s];
    end
    if (!reset_n) success_o = '0;
  end

  always_comb begin
    hold_d      = issue_valid_o & ~issue_ready_i;
    hold_slot_d = sel_slot;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) hold_q <= 1'b0;
    else          hold_q <= hold_d;
  end

  always_ff @(posedge clk) begin
    hold_slot_q <= hold_slot_d;
  end

endmodule

// File: tb/tb_back_icon_eu_rx_port.sv
// Bench for back_icon_eu_rx_port: table of single-cycle vectors, hand-written multi-cycle
// sequences, and an issue scoreboard checked whenever an op is handed to the EU.
`timescale 1ns/1ps
module tb_back_icon_eu_rx_port;
  import back_icon_eu_rx_port_pkg::*;

  localparam int NCH = 4;
  localparam int NS  = 4;
  localparam int DW  = 32;
  localparam int NV  = 24;

  localparam type_exec_unit_addr Z  = '{eu: 3'd0, unit: 3'd0};
  localparam type_exec_unit_addr TA = '{eu: 3'd2, unit: 3'd5};
  localparam type_exec_unit_addr TB = '{eu: 3'd3, unit: 3'd1};
  localparam type_exec_unit_addr TC = '{eu: 3'd4, unit: 3'd2};
  localparam type_exec_unit_addr TD = '{eu: 3'd1, unit: 3'd0};

  logic clk = 1'b0;
  logic reset_n;
  logic alloc_valid_i, alloc_ready_o;
  type_exec_unit_addr [1:0] alloc_tag_i;
  logic [1:0] alloc_rdy_i;
  logic [1:0][DW-1:0] alloc_data_i;
  logic [NCH-1:0] ch_en_i;
  type_exec_unit_addr [NCH-1:0] ch_src_i;
  logic [NCH-1:0][DW-1:0] ch_data_i;
  logic [NCH-1:0] success_o;
  logic issue_valid_o, issue_ready_i;
  logic [1:0][DW-1:0] issue_data_o;
  logic [1:0] issue_slot_o;

  int checks = 0;
  int errors = 0;

  typedef struct { int slot; logic [DW-1:0] d0; logic [DW-1:0] d1; } sb_t;
  sb_t sb_q[$];
  sb_t mon_e;

  typedef struct {
    logic av; type_exec_unit_addr t0; type_exec_unit_addr t1; logic [1:0] rdy;
    logic [DW-1:0] ad0; logic [DW-1:0] ad1;
    logic [NCH-1:0] en; type_exec_unit_addr [NCH-1:0] src; logic [NCH-1:0][DW-1:0] dat;
    logic ir; int es; int ear; int eiv; int eslot;
    logic push; int pslot; logic [DW-1:0] p0; logic [DW-1:0] p1;
  } vec_t;
  vec_t vec [NV];

  always #5 clk = ~clk;

  back_icon_eu_rx_port #(
    .NUM_ICON_CHANNELS (NCH),
    .NUM_SLOTS         (NS),
    .DATA_WIDTH        (DW),
    .EU_IDX            (0)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .alloc_valid_i (alloc_valid_i),
    .alloc_ready_o (alloc_ready_o),
    .alloc_tag_i   (alloc_tag_i),
    .alloc_rdy_i   (alloc_rdy_i),
    .alloc_data_i  (alloc_data_i),
    .ch_en_i       (ch_en_i),
    .ch_src_i      (ch_src_i),
    .ch_data_i     (ch_data_i),
    .success_o     (success_o),
    .issue_valid_o (issue_valid_o),
    .issue_ready_i (issue_ready_i),
    .issue_data_o  (issue_data_o),
    .issue_slot_o  (issue_slot_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int av, input type_exec_unit_addr t0, input type_exec_unit_addr t1,
                              input int rdy, input logic [DW-1:0] ad0, input logic [DW-1:0] ad1,
                              input int en, input type_exec_unit_addr [NCH-1:0] src,
                              input logic [NCH-1:0][DW-1:0] dat, input int ir,
                              input int es, input int ear, input int eiv, input int eslot,
                              input int push, input int pslot,
                              input logic [DW-1:0] p0, input logic [DW-1:0] p1);
    vec_t v;
    v.av = 1'(av); v.t0 = t0; v.t1 = t1; v.rdy = 2'(rdy); v.ad0 = ad0; v.ad1 = ad1;
    v.en = 4'(en); v.src = src; v.dat = dat; v.ir = 1'(ir);
    v.es = es; v.ear = ear; v.eiv = eiv; v.eslot = eslot;
    v.push = 1'(push); v.pslot = pslot; v.p0 = p0; v.p1 = p1;
    return v;
  endfunction

  task automatic push_sb(input int slot, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    sb_t e;
    e.slot = slot; e.d0 = d0; e.d1 = d1;
    sb_q.push_back(e);
  endtask

  task automatic clr;
    alloc_valid_i = 1'b0; alloc_tag_i = '0; alloc_rdy_i = '0; alloc_data_i = '0;
    ch_en_i = '0; ch_src_i = '0; ch_data_i = '0; issue_ready_i = 1'b0;
  endtask

  task automatic do_alloc(input type_exec_unit_addr t0, input type_exec_unit_addr t1, input logic [1:0] rdy,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    alloc_valid_i = 1'b1; alloc_tag_i[0] = t0; alloc_tag_i[1] = t1; alloc_rdy_i = rdy;
    alloc_data_i[0] = d0; alloc_data_i[1] = d1;
  endtask

  task automatic deliver(input int ch, input type_exec_unit_addr src, input logic [DW-1:0] d);
    ch_en_i[ch] = 1'b1; ch_src_i[ch] = src; ch_data_i[ch] = d;
  endtask

  function automatic type_exec_unit_addr ad(input int eu, input int u);
    type_exec_unit_addr a;
    a.eu = 3'(eu); a.unit = 3'(u);
    return a;
  endfunction

  // Check outputs mid-cycle, then move to just after the next rising edge.
  task automatic expect_out(input string tag, input int es, input int ear, input int eiv, input int eslot);
    @(negedge clk);
    chk({tag, "_success"}, success_o, es);
    chk({tag, "_alloc_ready"}, alloc_ready_o, ear);
    chk({tag, "_issue_valid"}, issue_valid_o, eiv);
    chk({tag, "_issue_slot"}, issue_slot_o, eslot);
    if (eiv == 0) chk({tag, "_issue_data_zero"}, issue_data_o, 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && issue_valid_o === 1'b1 && issue_ready_i === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_unexpected: slot %0d issued, expected nothing", issue_slot_o);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_issue_slot", issue_slot_o, mon_e.slot);
        chk("sb_issue_op0", issue_data_o[0], mon_e.d0);
        chk("sb_issue_op1", issue_data_o[1], mon_e.d1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vec[0]  = mk(1, TA, TB, 'b00, 'h0, 'h0, 'b0000, {Z, Z, Z, Z}, '0, 0, 'b0000, 1, 0, 0, 0, 0, 'h0, 'h0);
    vec[1]  = mk(0, Z, Z, 0, 'h0, 'h0, 'b0010, {Z, Z, TA, Z}, {32'h0, 32'h0, 32'hAA, 32'h0}, 0, 'b0010, 1, 0, 0, 0, 0, 'h0, 'h0);
    vec[2]  = mk(0, Z, Z, 0, 'h0, 'h0, 'b0001, {Z, Z, Z, TB}, {32'h0, 32'h0, 32'h0, 32'hBB}, 0, 'b0001, 1, 0, 0, 1, 0, 'hAA, 'hBB);
    vec[3]  = mk(0, Z, Z, 0, 'h0, 'h0, 'b0000, {Z, Z, Z, Z}, '0, 1, 'b0000, 1, 1, 0, 0, 0, 'h0, 'h0);
    vec[4]  = mk(0, Z, Z, 0, 'h0, 'h0, 'b0100, {Z, TC, Z, Z}, {32'h0, 32'hCC, 32'h0, 32'h0}, 0, 'b0000, 1, 0, 0, 0, 0, 'h0, 'h0);
    vec[5]  = mk(0, Z, Z, 0, 'h0, 'h0, 'b0100, {Z, TC, Z, Z}, {32'h0, 32'hCC, 32'h0, 32'h0}, 0, 'b0000, 1, 0, 0, 0, 0, 'h0, 'h0);
    vec[6]  = mk(1, TC, TA, 'b10, 'h0, 'h55, 'b0100, {Z, TC, Z, Z}, {32'h0, 32'hCC, 32'h0, 32'h0}, 0, 'b0100, 1, 0, 0, 1, 0, 'hCC, 'h55);
    vec[7]  = mk(0, Z, Z, 0, 'h0, 'h0, 'b0000, {Z, Z, Z, Z}, '0, 1, 'b0000, 1, 1, 0, 0, 0, 'h0, 'h0);
    vec[8]  = mk(1, TD, TB, 'b00, 'h0, 'h0, 'b0000, {Z, Z, Z, Z}, '0, 0, 'b0000, 1, 0, 0, 0, 0, 'h0, 'h0);
    vec[9]  = mk(0, Z, Z, 0, 'h0, 'h0, 'b1001, {TD, Z, Z, TD}, {32'h22, 32'h0, 32'h0, 32'h11}, 0, 'b1001, 1, 0, 0, 0, 0, 'h0, 'h0);
    vec[10] = mk(0, Z, Z, 0, 'h0, 'h0, 'b0010, {Z, Z, TB, Z}, {32'h0, 32'h0, 32'h33, 32'h0}, 0, 'b0010, 1, 0, 0, 1, 0, 'h11, 'h33);
    vec[11] = mk(0, Z, Z, 0, 'h0, 'h0, 'b0000, {Z, Z, Z, Z}, '0, 1, 'b0000, 1, 1, 0, 0, 0, 'h0, 'h0);
    vec[12] = mk(1, TD, TB, 'b00, 'h0, 'h0, 'b0000, {Z, Z, Z, Z}, '0, 0, 'b0000, 1, 0, 0, 0, 0, 'h0, 'h0);
    vec[13] = mk(1, TD, TA, 'b00, 'h0, 'h0, 'b0000, {Z, Z, Z, Z}, '0, 0, 'b0000, 1, 0, 0, 0, 0, 'h0, 'h0);
    vec[14] = mk(0, Z, Z, 0, 'h0, 'h0, 'b0100, {Z, TD, Z, Z}, {32'h0, 32'h44, 32'h0, 32'h0}, 0, 'b0100, 1, 0, 0, 0, 0, 'h0, 'h0);
    vec[15] = mk(0, Z, Z, 0, 'h0, 'h0, 'b0100, {Z, TD, Z, Z}, {32'h0, 32'h45, 32'h0, 32'h0}, 0, 'b0000, 1, 0, 0, 0, 0, 'h0, 'h0);
    vec[16] = mk(0, Z, Z, 0, 'h0, 'h0, 'b0010, {Z, Z, TB, Z}, {32'h0, 32'h0, 32'h66, 32'h0}, 0, 'b0010, 1, 0, 0, 1, 0, 'h44, 'h66);
    vec[17] = mk(0, Z, Z, 0, 'h0, 'h0, 'b1000, {TA, Z, Z, Z}, {32'h77, 32'h0, 32'h0, 32'h0}, 0, 'b1000, 1, 1, 0, 1, 1, 'h44, 'h77);
    vec[18] = mk(0, Z, Z, 0, 'h0, 'h0, 'b0000, {Z, Z, Z, Z}, '0, 1, 'b0000, 1, 1, 0, 0, 0, 'h0, 'h0);
    vec[19] = mk(0, Z, Z, 0, 'h0, 'h0, 'b0000, {Z, Z, Z, Z}, '0, 1, 'b0000, 1, 1, 1, 0, 0, 'h0, 'h0);
    vec[20] = mk(0, Z, Z, 0, 'h0, 'h0, 'b0000, {Z, Z, Z, Z}, '0, 0, 'b0000, 1, 0, 0, 0, 0, 'h0, 'h0);
    vec[21] = mk(1, TA, TB, 'b11, 'h1, 'h2, 'b0000, {Z, Z, Z, Z}, '0, 0, 'b0000, 1, 0, 0, 1, 0, 'h1, 'h2);
    vec[22] = mk(0, Z, Z, 0, 'h0, 'h0, 'b0000, {Z, Z, Z, Z}, '0, 1, 'b0000, 1, 1, 0, 0, 0, 'h0, 'h0);
    vec[23] = mk(0, Z, Z, 0, 'h0, 'h0, 'b0000, {Z, Z, Z, Z}, '0, 0, 'b0000, 1, 0, 0, 0, 0, 'h0, 'h0);

    reset_n = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    expect_out("reset", 0, 1, 0, 0);

    for (int i = 0; i < NV; i++) begin
      clr();
      alloc_valid_i = vec[i].av;
      alloc_tag_i[0] = vec[i].t0; alloc_tag_i[1] = vec[i].t1;
      alloc_rdy_i = vec[i].rdy;
      alloc_data_i[0] = vec[i].ad0; alloc_data_i[1] = vec[i].ad1;
      ch_en_i = vec[i].en; ch_src_i = vec[i].src; ch_data_i = vec[i].dat;
      issue_ready_i = vec[i].ir;
      if (vec[i].push) push_sb(vec[i].pslot, vec[i].p0, vec[i].p1);
      expect_out($sformatf("vec%0d", i), vec[i].es, vec[i].ear, vec[i].eiv, vec[i].eslot);
    end

    // Fill every slot, stall on a full port, then reuse the freed slot.
    clr(); do_alloc(ad(5, 0), ad(6, 0), 2'b00, 0, 0);         expect_out("full_a0", 0, 1, 0, 0);
    clr(); do_alloc(ad(5, 1), ad(6, 1), 2'b00, 0, 0);         expect_out("full_a1", 0, 1, 0, 0);
    clr(); do_alloc(ad(7, 2), ad(7, 3), 2'b11, 'h20, 'h21);
    push_sb(2, 'h20, 'h21);                                   expect_out("full_a2", 0, 1, 0, 0);
    clr(); do_alloc(ad(5, 3), ad(6, 3), 2'b00, 0, 0);         expect_out("full_a3", 0, 1, 1, 2);
    clr(); do_alloc(ad(0, 7), ad(0, 6), 2'b00, 0, 0);
    deliver(0, ad(0, 7), 'h99);                               expect_out("full_ignored", 0, 0, 1, 2);
    clr(); issue_ready_i = 1'b1;                              expect_out("full_issue2", 0, 0, 1, 2);
    clr(); do_alloc(ad(7, 7), ad(7, 6), 2'b11, 'h30, 'h31);
    push_sb(2, 'h30, 'h31);                                   expect_out("reuse_a2", 0, 1, 0, 0);
    clr(); issue_ready_i = 1'b1;                              expect_out("reuse_issue2", 0, 0, 1, 2);

    // Stalled issue keeps slot 1 while slot 0 becomes ready underneath it.
    clr();
    deliver(0, ad(5, 1), 'h41); deliver(1, ad(6, 1), 'h42);
    deliver(2, ad(5, 3), 'h43); deliver(3, ad(6, 3), 'h44);
    push_sb(1, 'h41, 'h42);                                   expect_out("hold_fill", 'b1111, 1, 0, 0);
    clr(); deliver(0, ad(5, 0), 'h50);                        expect_out("hold_s0", 'b0001, 1, 1, 1);
    clr(); deliver(0, ad(6, 0), 'h51);
    push_sb(0, 'h50, 'h51); push_sb(3, 'h43, 'h44);           expect_out("hold_s1", 'b0001, 1, 1, 1);
    clr();                                                    expect_out("hold_frozen", 0, 1, 1, 1);
    clr(); issue_ready_i = 1'b1;                              expect_out("hold_fire1", 0, 1, 1, 1);
    clr(); issue_ready_i = 1'b1;                              expect_out("hold_fire0", 0, 1, 1, 0);
    clr(); issue_ready_i = 1'b1;                              expect_out("hold_fire3", 0, 1, 1, 3);
    clr();                                                    expect_out("hold_empty", 0, 1, 0, 0);

    // Reset with three waiting slots discards them.
    clr(); do_alloc(ad(1, 1), ad(1, 2), 2'b00, 0, 0);         expect_out("rst_a0", 0, 1, 0, 0);
    clr(); do_alloc(ad(1, 3), ad(1, 4), 2'b00, 0, 0);         expect_out("rst_a1", 0, 1, 0, 0);
    clr(); do_alloc(ad(1, 5), ad(1, 6), 2'b00, 0, 0);         expect_out("rst_a2", 0, 1, 0, 0);
    clr(); reset_n = 1'b0;
    deliver(0, ad(1, 1), 'h5); deliver(1, ad(1, 4), 'h6);     expect_out("rst_cycle", 0, 1, 0, 0);
    clr(); reset_n = 1'b1;
    deliver(0, ad(1, 1), 'h5); deliver(1, ad(1, 4), 'h6);     expect_out("rst_after", 0, 1, 0, 0);
    clr(); do_alloc(ad(1, 1), ad(1, 2), 2'b00, 0, 0);
    deliver(0, ad(1, 1), 'h77); deliver(1, ad(1, 4), 'h6);    expect_out("rst_bypass", 'b0001, 1, 0, 0);
    clr(); deliver(0, ad(1, 2), 'h78);
    push_sb(0, 'h77, 'h78);                                   expect_out("rst_fill", 'b0001, 1, 0, 0);
    clr(); issue_ready_i = 1'b1;                              expect_out("rst_issue", 0, 1, 1, 0);
    clr();                                                    expect_out("final_idle", 0, 1, 0, 0);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
